// File: rtl/pulp_clkgate_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pulp_clkgate_pkg                                             |
// | Description : Shared types for the asynchronous-enable multi-channel       |
// |               clock gate: per-channel gate FSM state encoding.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pulp_clkgate_pkg;

  // Per-channel gate state. DRAIN is the hysteresis window between the synced
  // enable dropping and the clock actually being gated off.
  typedef enum logic [1:0] {
    CG_OFF   = 2'd0,
    CG_ON    = 2'd1,
    CG_DRAIN = 2'd2
  } cg_state_e;

endpackage : pulp_clkgate_pkg
`default_nettype wire

// File: rtl/pulp_clock_gating.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pulp_clock_gating                                            |
// | Description : Technology ICG wrapper. Latch-based integrated clock gate;   |
// |               the enable is captured while clk_i is low so clk_o never     |
// |               carries a truncated pulse.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports:                                                                     |
// |   clk_i      in  1  source clock                                           |
// |   en_i       in  1  functional enable (must be registered in clk_i domain) |
// |   test_en_i  in  1  DFT enable, ORed with en_i ahead of the latch          |
// |   clk_o      out 1  gated clock                                            |
// +----------------------------------------------------------------------------+
module pulp_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latch;

  // Transparent during the low phase only; holds through the high phase.
  always_latch begin
    if (!clk_i) begin
      en_latch = en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & en_latch;

endmodule : pulp_clock_gating
`default_nettype wire

// File: rtl/pulp_clock_gating_async_ch.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pulp_clock_gating_async_ch                                   |
// | Description : One clock-gating channel: enable synchroniser, gate FSM      |
// |               with off-delay hysteresis counter, and ICG.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports:                                                                     |
// |   clk_i       in  1  ungated source clock                                  |
// |   rstn_i      in  1  asynchronous active-low reset                         |
// |   en_async_i  in  1  enable request, asynchronous to clk_i                 |
// |   test_en_i   in  1  DFT override, forces clk_o running                    |
// |   clk_o       out 1  gated clock                                           |
// |   en_ack_o    out 1  gate state (1 = clk_o enabled)                        |
// +----------------------------------------------------------------------------+
module pulp_clock_gating_async_ch
  import pulp_clkgate_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OFF_DELAY   = 4,
  parameter logic        RESET_EN    = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_async_i,
  input  logic test_en_i,
  output logic clk_o,
  output logic en_ack_o
);

  // A zero off-delay still needs a 1-bit counter so the declarations stay legal.
  localparam int unsigned CNT_W = (OFF_DELAY > 0) ? $clog2(OFF_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (OFF_DELAY > 0) ? CNT_W'(OFF_DELAY - 1) : '0;
  localparam cg_state_e RESET_STATE = RESET_EN ? CG_ON : CG_OFF;

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   sync_out;
  cg_state_e              state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic                   gate_en;

  // Synchroniser: resets to the channel's reset gate state so the FSM does not
  // see a spurious edge when reset is released.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], en_async_i};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CG_ON: begin
        if (!sync_out) begin
          if (OFF_DELAY == 0) begin
            state_d = CG_OFF;
          end else begin
            state_d = CG_DRAIN;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      CG_DRAIN: begin
        if (sync_out) begin
          state_d = CG_ON;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = CG_OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CG_OFF: begin
        if (sync_out) begin
          state_d = CG_ON;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q  <= {SYNC_STAGES{RESET_EN}};
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gate enable comes straight from state flops, never from en_async_i.
  assign gate_en  = (state_q != CG_OFF);
  assign en_ack_o = gate_en;

  pulp_clock_gating u_icg (
    .clk_i     (clk_i),
    .en_i      (gate_en),
    .test_en_i (test_en_i),
    .clk_o     (clk_o)
  );

endmodule : pulp_clock_gating_async_ch
`default_nettype wire

// File: rtl/pulp_clock_gating_async_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pulp_clock_gating_async_multi                                |
// | Description : Multi-channel clock gate with asynchronous enables,          |
// |               off-delay hysteresis and per-channel gate acknowledge.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports:                                                                     |
// |   clk_i       in  1       ungated source clock                             |
// |   rstn_i      in  1       asynchronous active-low reset                    |
// |   en_async_i  in  NUM_CH  per-channel enable request (asynchronous, level) |
// |   test_en_i   in  1       DFT override, forces every clk_o running         |
// |   clk_o       out NUM_CH  gated clocks                                     |
// |   en_ack_o    out NUM_CH  per-channel gate state (1 = clk_o enabled)      |
// +----------------------------------------------------------------------------+
module pulp_clock_gating_async_multi
  import pulp_clkgate_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       OFF_DELAY   = 4,
  parameter logic [NUM_CH-1:0] RESET_EN    = '1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NUM_CH-1:0] en_async_i,
  input  logic              test_en_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] en_ack_o
);

  if (SYNC_STAGES < 2) begin : g_chk_sync_stages
    $error("pulp_clock_gating_async_multi: SYNC_STAGES must be >= 2");
  end

  if (NUM_CH < 1) begin : g_chk_num_ch
    $error("pulp_clock_gating_async_multi: NUM_CH must be >= 1");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pulp_clock_gating_async_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .OFF_DELAY   (OFF_DELAY),
      .RESET_EN    (RESET_EN[c])
    ) u_ch (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .en_async_i (en_async_i[c]),
      .test_en_i  (test_en_i),
      .clk_o      (clk_o[c]),
      .en_ack_o   (en_ack_o[c])
    );
  end

endmodule : pulp_clock_gating_async_multi
`default_nettype wire

// File: tb/tb_pulp_clock_gating_async_multi.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pulp_clock_gating_async_multi                             |
// | Description : Self-checking bench. Reference: a channel's gate is on after |
// |               edge n iff any enable sample taken at edges n-S-D .. n-S    |
// |               was high (reset fills the history with RESET_EN).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pulp_clock_gating_async_multi;

  localparam int          N   = 4;
  localparam int          S   = 2;
  localparam int          D   = 4;
  localparam logic [N-1:0] RST = 4'b0101;
  localparam int          HW  = S + D + 1;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [N-1:0] en_async_i;
  logic         test_en_i;
  logic [N-1:0] clk_o;
  logic [N-1:0] en_ack_o;

  int n_tests = 0;
  int n_fail  = 0;

  // hist[c][k] = enable sample of channel c taken k edges ago (k=0 newest).
  logic hist [N][HW];
  logic [N-1:0] exp_gate;
  logic [N-1:0] exp_ack;

  pulp_clock_gating_async_multi #(
    .NUM_CH      (N),
    .SYNC_STAGES (S),
    .OFF_DELAY   (D),
    .RESET_EN    (RST)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_async_i (en_async_i),
    .test_en_i  (test_en_i),
    .clk_o      (clk_o),
    .en_ack_o   (en_ack_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] window();
    logic [N-1:0] w;
    for (int c = 0; c < N; c++) begin
      w[c] = 1'b0;
      for (int k = S; k <= S + D; k++) w[c] = w[c] | hist[c][k];
    end
    return w;
  endfunction

  task automatic hist_fill();
    for (int c = 0; c < N; c++)
      for (int k = 0; k < HW; k++) hist[c][k] = RST[c];
  endtask

  task automatic hist_shift(input logic [N-1:0] en);
    for (int c = 0; c < N; c++) begin
      for (int k = HW - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = en[c];
    end
  endtask

  // Model compare: the high phase after an edge shows the gate state that held
  // before the edge; the low phase is always flat.
  always @(posedge clk_i) begin
    if (!rstn_i) begin
      hist_fill();
      exp_gate = RST;
      exp_ack  = RST;
    end else begin
      exp_gate = window();
      hist_shift(en_async_i);
      exp_ack  = window();
    end
    #1;
    check("cmp_clk_high", clk_o, exp_gate | {N{test_en_i}});
    check("cmp_ack", en_ack_o, exp_ack);
  end

  always @(negedge clk_i) begin
    #1;
    check("cmp_clk_low", clk_o, '0);
  end

  task automatic edge_step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int hold;
    rstn_i     = 1'b1;
    en_async_i = '0;
    test_en_i  = 1'b0;
    hist_fill();
    #1 rstn_i  = 1'b0;

    // Reset state: channels 0 and 2 run, 1 and 3 flat.
    edge_step();
    edge_step();
    check("rst_ack", en_ack_o, 4'b0101);
    check("rst_clk_high", clk_o, 4'b0101);
    @(negedge clk_i); #1;
    check("rst_clk_low", clk_o, 4'b0000);

    @(negedge clk_i);
    en_async_i = 4'b0101;
    rstn_i     = 1'b1;
    repeat (10) edge_step();

    // Rise on channel 1: ack after edge 2, first pulse at edge 3.
    @(negedge clk_i);
    en_async_i = 4'b0111;
    edge_step();                       // edge 0
    edge_step();                       // edge 1
    check("rise_ack_e1", en_ack_o, 4'b0101);
    edge_step();                       // edge 2
    check("rise_ack_e2", en_ack_o, 4'b0111);
    check("rise_clk_e2", clk_o, 4'b0101);
    edge_step();                       // edge 3
    check("rise_clk_e3", clk_o, 4'b0111);
    repeat (4) edge_step();

    // Fall on channel 0: last pulse at edge 6, ack low after edge 6.
    @(negedge clk_i);
    en_async_i = 4'b0110;
    repeat (6) edge_step();            // edges 0..5
    check("fall_ack_e5", en_ack_o, 4'b0111);
    check("fall_clk_e5", clk_o, 4'b0111);
    edge_step();                       // edge 6
    check("fall_ack_e6", en_ack_o, 4'b0110);
    check("fall_clk_e6", clk_o, 4'b0111);
    edge_step();                       // edge 7
    check("fall_clk_e7", clk_o, 4'b0110);

    // Short drop on channel 0 is absorbed by the hysteresis.
    @(negedge clk_i);
    en_async_i = 4'b0111;
    repeat (8) edge_step();
    @(negedge clk_i);
    en_async_i = 4'b0110;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    en_async_i = 4'b0111;
    for (int i = 0; i < 12; i++) begin
      edge_step();
      check("drop_ack_ch0", {3'b000, en_ack_o[0]}, 4'b0001);
      check("drop_clk_ch0", {3'b000, clk_o[0]}, 4'b0001);
    end

    // Asynchronous reset while channels 1 and 2 drain.
    @(negedge clk_i);
    en_async_i = 4'b0001;
    repeat (4) @(posedge clk_i);       // edges 0..3: ch2 DRAIN with cnt=2
    #3;
    check("pre_rst_ack", en_ack_o, 4'b0111);
    rstn_i = 1'b0;
    #1;
    check("async_rst_ack", en_ack_o, 4'b0101);
    repeat (2) edge_step();
    @(negedge clk_i);
    en_async_i = 4'b0101;
    rstn_i     = 1'b1;

    // Everything off, then DFT override.
    @(negedge clk_i);
    en_async_i = 4'b0000;
    repeat (12) edge_step();
    check("off_ack", en_ack_o, 4'b0000);
    check("off_clk", clk_o, 4'b0000);
    @(negedge clk_i);
    test_en_i = 1'b1;
    edge_step();
    check("te_clk", clk_o, 4'b1111);
    check("te_ack", en_ack_o, 4'b0000);
    @(negedge clk_i);
    test_en_i = 1'b0;
    edge_step();
    check("te_release_clk", clk_o, 4'b0000);

    // Randomised enables, changed inside the low phase.
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      #($urandom_range(1, 3));
      if (hold == 0) begin
        en_async_i = N'($urandom);
        hold       = $urandom_range(1, 10);
      end
      hold--;
      test_en_i = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk_i);
    test_en_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pulp_clock_gating_async_multi
`default_nettype wire
